regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the NPC core: NRD async read

---
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with async reads, sync writes, optional
// write-to-read forwarding, hardwired x0, a pending scoreboard and a post-reset clear sweep.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    output logic                init_done
);

    typedef enum logic {INIT, READY} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The sweep visits every register once; the last one written is NREG-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_done = 1'b0;
        case (state)
            INIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == AW'(NREG - 1))
                    state_nxt = READY;
            end
            READY: init_done = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    // Ascending port order makes the highest-index port win on an address clash.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[cnt] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && !(ZERO_REG != 0 && waddr[j*AW +: AW] == '0))
                    regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
            end
        end
    end

    // Issue is applied after the clears so a younger producer keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else if (state == READY) begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j])
                    pending[waddr[j*AW +: AW]] <= 1'b0;
            end
            if (issue_en && !(ZERO_REG != 0 && issue_addr == '0))
                pending[issue_addr] <= 1'b1;
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] fwd;
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = raddr[i*AW +: AW];
            hit = 1'b0;
            fwd = '0;
            for (int j = 0; j < NWR; j++) begin
                if (BYPASS != 0 && wen[j] && waddr[j*AW +: AW] == ra) begin
                    hit = 1'b1;
                    fwd = wdata[j*XLEN +: XLEN];
                end
            end
            if (state == READY && !(ZERO_REG != 0 && ra == '0)) begin
                rdata[i*XLEN +: XLEN] = hit ? fwd : regs[ra];
                rbusy[i]              = pending[ra] && !hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp; one forwarding and one
// non-forwarding instance share inputs and are checked against a behavioural model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 3;
    localparam int NWR  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata, rdata_nb;
    logic [NRD-1:0]      rbusy, rbusy_nb;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                init_done, init_done_nb;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) u_bp (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .issue_en(issue_en),
        .issue_addr(issue_addr), .init_done(init_done)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) u_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata), .issue_en(issue_en),
        .issue_addr(issue_addr), .init_done(init_done_nb)
    );

    logic [XLEN-1:0] mreg [NREG];
    bit              mpend [NREG];
    int              init_left   = NREG;
    bit              model_valid = 1'b0;
    int              n_checks    = 0;
    int              n_fail      = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra, input bit bp);
        logic [XLEN-1:0] v;
        if (init_left != 0 || ra == '0) return '0;
        v = mreg[ra];
        if (bp)
            for (int j = 0; j < NWR; j++)
                if (wen[j] && waddr[j*AW +: AW] == ra) v = wdata[j*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] ra, input bit bp);
        bit hit;
        hit = 1'b0;
        if (init_left != 0 || ra == '0) return 1'b0;
        if (bp)
            for (int j = 0; j < NWR; j++)
                if (wen[j] && waddr[j*AW +: AW] == ra) hit = 1'b1;
        return mpend[ra] && !hit;
    endfunction

    task automatic check_outputs();
        logic [NRD*XLEN-1:0] erd, erd_nb;
        logic [NRD-1:0]      eb, eb_nb;
        for (int i = 0; i < NRD; i++) begin
            erd[i*XLEN +: XLEN]    = exp_rd(raddr[i*AW +: AW], 1'b1);
            erd_nb[i*XLEN +: XLEN] = exp_rd(raddr[i*AW +: AW], 1'b0);
            eb[i]                  = exp_busy(raddr[i*AW +: AW], 1'b1);
            eb_nb[i]               = exp_busy(raddr[i*AW +: AW], 1'b0);
        end
        chk("rdata_bp", 128'(rdata), 128'(erd));
        chk("rdata_nb", 128'(rdata_nb), 128'(erd_nb));
        chk("rbusy_bp", 128'(rbusy), 128'(eb));
        chk("rbusy_nb", 128'(rbusy_nb), 128'(eb_nb));
        chk("init_done_bp", 128'(init_done), 128'(init_left == 0));
        chk("init_done_nb", 128'(init_done_nb), 128'(init_left == 0));
    endtask

    task automatic model_step();
        logic [AW-1:0] a;
        if (rst) begin
            init_left   = NREG;
            model_valid = 1'b1;
            for (int k = 0; k < NREG; k++) mpend[k] = 1'b0;
        end else if (init_left != 0) begin
            mreg[NREG - init_left] = '0;
            init_left--;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j]) begin
                    a = waddr[j*AW +: AW];
                    if (a != '0) mreg[a] = wdata[j*XLEN +: XLEN];
                    mpend[a] = 1'b0;
                end
            end
            if (issue_en && issue_addr != '0) mpend[issue_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (model_valid) check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wen      = '0;
        waddr    = '0;
        wdata    = '0;
        issue_en = 1'b0;
        issue_addr = '0;
        raddr    = '0;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        raddr[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wen[j]                = 1'b1;
        waddr[j*AW +: AW]     = a;
        wdata[j*XLEN +: XLEN] = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int k = 0; k < NREG; k++) begin
            mreg[k]  = '0;
            mpend[k] = 1'b0;
        end

        // T1: reset, sweep timing, writes ignored during the sweep
        tick();
        rst = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            idle();
            set_wr(0, AW'(k % 8 + 1), 32'hA5A5_0000 + k);
            issue_en   = 1'b1;
            issue_addr = AW'(k % 8 + 1);
            set_rd(0, AW'(k % 8 + 1));
            tick();
            chk("init_done_sweep", 128'(init_done), 128'(k == NREG - 1));
        end
        idle();
        for (int k = 0; k < NREG; k += NRD) begin
            for (int i = 0; i < NRD; i++) set_rd(i, AW'((k + i) % NREG));
            #2;
            chk("cleared_reg", 128'(rdata), 128'(0));
            chk("cleared_busy", 128'(rbusy), 128'(0));
            tick();
        end

        // T2: same-cycle forwarding vs old value
        idle();
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        set_rd(0, 5'd5);
        #2;
        chk("fwd_bp", 128'(rdata[0 +: XLEN]), 128'(32'hDEAD_BEEF));
        chk("fwd_nb_old", 128'(rdata_nb[0 +: XLEN]), 128'(0));
        tick();
        idle();
        set_rd(0, 5'd5);
        #2;
        chk("fwd_nb_new", 128'(rdata_nb[0 +: XLEN]), 128'(32'hDEAD_BEEF));
        tick();

        // T3: write-port priority and hardwired zero
        idle();
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        tick();
        idle();
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        set_rd(1, 5'd7);
        tick();
        idle();
        set_rd(0, 5'd0);
        set_rd(1, 5'd7);
        #2;
        chk("x0_zero", 128'(rdata[0 +: XLEN]), 128'(0));
        chk("x7_prio", 128'(rdata_nb[XLEN +: XLEN]), 128'(32'h22));
        tick();

        // T4: scoreboard set / clear / set-wins
        idle();
        issue_en = 1'b1;
        issue_addr = 5'd9;
        tick();
        idle();
        set_rd(0, 5'd9);
        #2;
        chk("busy_after_issue", 128'(rbusy[0]), 128'(1));
        tick();
        idle();
        set_rd(0, 5'd9);
        set_wr(0, 5'd9, 32'h99);
        #2;
        chk("busy_fwd_clear", 128'(rbusy[0]), 128'(0));
        chk("busy_nb_same_cycle", 128'(rbusy_nb[0]), 128'(1));
        tick();
        idle();
        set_rd(0, 5'd9);
        #2;
        chk("busy_cleared", 128'(rbusy_nb[0]), 128'(0));
        tick();
        idle();
        issue_en = 1'b1;
        issue_addr = 5'd9;
        set_wr(1, 5'd9, 32'h98);
        tick();
        idle();
        set_rd(2, 5'd9);
        #2;
        chk("set_wins", 128'(rbusy[2]), 128'(1));
        tick();

        // T5: reset in the middle of the sweep
        idle();
        set_wr(0, 5'd3, 32'h55);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            tick();
            chk("init_done_restart", 128'(init_done_nb), 128'(k == NREG - 1));
        end
        set_rd(0, 5'd3);
        set_rd(1, 5'd9);
        #2;
        chk("x3_cleared", 128'(rdata[0 +: XLEN]), 128'(0));
        chk("pend_cleared", 128'(rbusy_nb[1]), 128'(0));
        tick();

        // T6: random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            idle();
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NRD; i++)
                set_rd(i, AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : NREG - 1)));
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 2) == 0)
                    set_wr(j, AW'($urandom_range(0, 7)), $urandom);
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = AW'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
